crct_eval_arbiter: RTL and testbench

- Shares one combinational evaluation circuit among NREQ requesters. The circuit has operand inputs A, B, C and results x = (A&B)|~C, y = ~C.
- Arbitrates requests round-robin and drives the circuit's A/B/C.
- Waits a programmable settle time to cover gate propagation, then captures x/y and returns them with a done pulse.
- Sits between requesting blocks and the gate-level circuit; the circuit itself is outside this block.

---
 rtl/crct_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/crct_eval_arbiter.sv | 101 ++++++++++
 tb/tb_crct_eval_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/crct_pkg.sv
// rtl/crct_pkg.sv - shared state encoding, settle default and reference functions
package crct_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int SETTLE_DEFAULT = 3;

  function automatic logic x_ref(input logic a, input logic b, input logic c);
    return (a & b) | ~c;
  endfunction

  function automatic logic y_ref(input logic c);
    return ~c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set req at or after ptr
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   winner,
  output logic            valid
);

  int cand;

  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = PW'(cand);
      end
    end
    if (valid) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/crct_eval_arbiter.sv
// rtl/crct_eval_arbiter.sv - round-robin shared access to an external x/y evaluation circuit
module crct_eval_arbiter
  import crct_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] abc_in,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic              x_out,
  output logic              y_out,
  output logic              A,
  output logic              B,
  output logic              C,
  input  logic              x_in,
  input  logic              y_in
);

  // A settle of zero would sample before the operands are even driven
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW         = $clog2(SETTLE_EFF) + 1;
  localparam int PW         = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [NREQ-1:0] arb_gnt;
  logic            arb_valid;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .gnt    (arb_gnt),
    .winner (winner),
    .valid  (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arb_valid) state_nxt = ST_SETTLE;
      ST_SETTLE: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Operands and results are held between operations so the circuit stays quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt   <= '0;
      cnt   <= '0;
      ptr   <= '0;
      A     <= 1'b0;
      B     <= 1'b0;
      C     <= 1'b0;
      x_out <= 1'b0;
      y_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt       <= arb_gnt;
            {A, B, C} <= abc_in[3*int'(winner) +: 3];
            cnt       <= CW'(SETTLE_EFF - 1);
            ptr       <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            x_out <= x_in;
            y_out <= y_in;
          end
        end
        ST_DONE: gnt <= '0;
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_crct_eval_arbiter.sv
// tb/tb_crct_eval_arbiter.sv - self-checking bench with delayed gate model and reference model
module tb_crct_eval_arbiter;

  localparam int NREQ   = 2;
  localparam int SETTLE = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [5:0]      abc_in = '0;
  logic [NREQ-1:0] gnt;
  logic            busy, done, x_out, y_out, A, B, C;
  wire             x_in, y_in;
  wire             ab_w, nc_w;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  logic [2:0] last_abc = 3'b000;
  logic       last_x = 1'b0;
  logic       last_y = 1'b0;

  always #10 clk = ~clk;

  // Gate-level circuit with AND 30, NOT 10, OR 20: worst path 50 < 3 clocks of 20
  assign #30 ab_w = A & B;
  assign #10 nc_w = ~C;
  assign #20 x_in = ab_w | nc_w;
  assign y_in = nc_w;

  crct_eval_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .abc_in (abc_in),
    .gnt    (gnt),
    .busy   (busy),
    .done   (done),
    .x_out  (x_out),
    .y_out  (y_out),
    .A      (A),
    .B      (B),
    .C      (C),
    .x_in   (x_in),
    .y_in   (y_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full operation; entered and left at a falling edge
  task automatic run_op(input logic [1:0] r, input logic [5:0] abc, input int w,
                        input logic ex, input logic ey, input bit drop);
    logic [2:0] opd;
    logic [5:0] sh;
    logic [1:0] exp_gnt;
    sh      = abc >> (3 * w);
    opd     = sh[2:0];
    exp_gnt = 2'(1 << w);
    req    = r;
    abc_in = abc;
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(exp_gnt));
    chk("busy_op", 32'(busy), 32'd1);
    chk("abc_drive", 32'({A, B, C}), 32'(opd));
    chk("done_early", 32'(done), 32'd0);
    if (drop) begin
      req    = '0;
      abc_in = ~abc;
    end
    for (int k = 1; k < SETTLE; k++) begin
      @(negedge clk);
      chk("done_settle", 32'(done), 32'd0);
      chk("gnt_hold", 32'(gnt), 32'(exp_gnt));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("x_out", 32'(x_out), 32'(ex));
    chk("y_out", 32'(y_out), 32'(ey));
    chk("gnt_done", 32'(gnt), 32'(exp_gnt));
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("gnt_clear", 32'(gnt), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("abc_hold", 32'({A, B, C}), 32'(opd));
    last_abc = opd;
    last_x   = ex;
    last_y   = ey;
  endtask

  task automatic idle_cycle();
    req = '0;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_abc", 32'({A, B, C}), 32'(last_abc));
    chk("idle_xy", 32'({x_out, y_out}), 32'({last_x, last_y}));
  endtask

  typedef struct {
    logic [1:0] r;
    logic [5:0] abc;
    int         w;
    logic       ex;
    logic       ey;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 6'b000_110, 0, 1'b1, 1'b1};
    vecs[1] = '{2'b01, 6'b000_111, 0, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 6'b000_001, 0, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 6'b000_000, 0, 1'b1, 1'b1};
    vecs[4] = '{2'b10, 6'b101_000, 1, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 6'b100_111, 0, 1'b1, 1'b0};
    vecs[6] = '{2'b11, 6'b100_111, 1, 1'b1, 1'b1};
    vecs[7] = '{2'b11, 6'b100_111, 0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
    end

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].r, vecs[i].abc, vecs[i].w, vecs[i].ex, vecs[i].ey, 1'b0);
    end
    ptr_m = 1;

    // req[1] dropped and operands scrambled after grant: result from granted operands
    run_op(2'b10, 6'b111_000, 1, 1'b1, 1'b0, 1'b1);
    ptr_m = 0;
    idle_cycle();

    for (int n = 0; n < 30; n++) begin
      logic [1:0] r;
      logic [5:0] abc;
      logic [5:0] sh;
      int w;
      bit drop;
      logic a, b, c;
      r    = 2'($urandom_range(1, 3));
      abc  = 6'($urandom);
      drop = ($urandom_range(0, 3) == 0);
      w    = -1;
      for (int off = 0; off < NREQ; off++) begin
        int cidx;
        cidx = (ptr_m + off) % NREQ;
        if (w < 0 && r[cidx]) w = cidx;
      end
      sh = abc >> (3 * w);
      a  = sh[2];
      b  = sh[1];
      c  = sh[0];
      run_op(r, abc, w, (a & b) | ~c, ~c, drop);
      ptr_m = (w + 1) % NREQ;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        idle_cycle();
      end
    end

    // Async reset in the middle of SETTLE after a grant that leaves the pointer at 1
    req    = 2'b01;
    abc_in = 6'b000_111;
    @(negedge clk);
    chk("pre_reset_gnt", 32'(gnt), 32'd1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_abc", 32'({A, B, C}), 32'd0);
    chk("rst_xy", 32'({x_out, y_out}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    run_op(2'b11, 6'b011_110, 0, 1'b1, 1'b1, 1'b0);
    run_op(2'b10, 6'b011_110, 1, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
